gray_fifo: RTL and testbench

- Parametrised synchronous FIFO. Successor to the team's fixed 8-entry, 3-bit gray-pointer FIFO.
- Generalised in width and depth (power of two). Uses the full 2**ADDR_WIDTH capacity; no slot is wasted.
- Separate write and read data ports replace the shared inout bus.
- Adds:
  - a selectable first-word-fall-through (FWFT) mode;
  - an occupancy count;
  - almost-full and almost-empty flags;
  - sticky overflow and underflow errors;
  - a synchronous flush.
- Sits between producer and consumer datapaths in one clock domain. Its gray-coded pointers are reusable by a later async variant.

---
 rtl/fifo_pkg.sv | 37 +++
 rtl/gray_fifo_ptr.sv | 28 ++
 rtl/gray_fifo.sv | 98 +++++++++
 tb/tb_gray_fifo.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the gray-pointer FIFO family: gray/binary conversion and clog2.
package fifo_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 3;
  localparam int GRAY_MAX_WIDTH = 32;

  function automatic logic [GRAY_MAX_WIDTH-1:0] width_mask(input int width);
    if (width >= GRAY_MAX_WIDTH) return '1;
    return (GRAY_MAX_WIDTH'(1) << width) - GRAY_MAX_WIDTH'(1);
  endfunction

  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] bin,
                                                        input int width);
    logic [GRAY_MAX_WIDTH-1:0] b;
    b = bin & width_mask(width);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] gray,
                                                        input int width);
    logic [GRAY_MAX_WIDTH-1:0] g;
    logic [GRAY_MAX_WIDTH-1:0] b;
    g = gray & width_mask(width);
    b = '0;
    b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/gray_fifo_ptr.sv
// Gray-coded wrap-around pointer; the register holds gray so it can later cross clock domains.
module gray_fifo_ptr
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                inc,
  output logic [ADDR_WIDTH:0] ptr_gray,
  output logic [ADDR_WIDTH:0] ptr_bin
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH:0] bin_next;

  assign ptr_bin  = PW'(gray2bin(GRAY_MAX_WIDTH'(ptr_gray), PW));
  assign bin_next = ptr_bin + PW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       ptr_gray <= '0;
    else if (clr)   ptr_gray <= '0;
    else if (inc)   ptr_gray <= PW'(bin2gray(GRAY_MAX_WIDTH'(bin_next), PW));
  end

endmodule

// File: rtl/gray_fifo.sv
// Single-clock FIFO with gray pointers, optional first-word-fall-through, level flags and sticky errors.
module gray_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 2**ADDR_WIDTH;
  // Inverting the top two gray bits marks "same slot, one lap ahead".
  localparam logic [ADDR_WIDTH:0] FULL_MASK = PW'(3) << (ADDR_WIDTH - 1);

  logic [ADDR_WIDTH:0]   wptr_gray, wptr_bin, rptr_gray, rptr_bin;
  logic [ADDR_WIDTH-1:0] waddr, raddr;
  logic                  wr_ok, rd_ok;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign wr_ok = wr_en && !full && !clr;
  assign rd_ok = rd_en && !empty && !clr;
  assign waddr = wptr_bin[ADDR_WIDTH-1:0];
  assign raddr = rptr_bin[ADDR_WIDTH-1:0];

  gray_fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wptr (
    .clk(clk), .rst(rst), .clr(clr), .inc(wr_ok),
    .ptr_gray(wptr_gray), .ptr_bin(wptr_bin)
  );

  gray_fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rptr (
    .clk(clk), .rst(rst), .clr(clr), .inc(rd_ok),
    .ptr_gray(rptr_gray), .ptr_bin(rptr_bin)
  );

  // Flags and count depend only on pointer registers, so they settle the cycle after each edge.
  assign empty        = (wptr_gray == rptr_gray);
  assign full         = (wptr_gray == (rptr_gray ^ FULL_MASK));
  assign count        = wptr_bin - rptr_bin;
  assign almost_full  = int'(count) >= AF_LEVEL;
  assign almost_empty = int'(count) <= AE_LEVEL;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[waddr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign rd_data  = empty ? '0 : mem[raddr];
    assign rd_valid = !empty;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_ok;
        if (rd_ok) rd_data_q <= mem[raddr];
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_gray_fifo.sv
// Directed bench for gray_fifo: registered-read instance plus a first-word-fall-through instance.
module tb_gray_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic [7:0] rd_data;
  logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;

  logic       wr_en1 = 1'b0, rd_en1 = 1'b0;
  logic [7:0] wr_data1 = '0;
  logic [7:0] rd_data1;
  logic       rd_valid1, full1, empty1, almost_full1, almost_empty1, overflow1, underflow1;
  logic [3:0] count1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  gray_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .FWFT(0)) dut (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  gray_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .FWFT(1)) dut_fwft (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en1), .wr_data(wr_data1), .rd_en(rd_en1),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1), .empty(empty1),
    .almost_full(almost_full1), .almost_empty(almost_empty1), .count(count1),
    .overflow(overflow1), .underflow(underflow1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ae", 32'(almost_empty), 1);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_udf", 32'(underflow), 0);
    chk("rst_fwft_valid", 32'(rd_valid1), 0);
    rst = 1'b1;

    // fill 0x10..0x17
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(8'h10 + i);
      tick();
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_af", 32'(almost_full), (i + 1 >= 7) ? 1 : 0);
      chk("fill_full", 32'(full), (i == 7) ? 1 : 0);
      chk("fill_empty", 32'(empty), 0);
    end

    // write while full: rejected, sticky overflow
    wr_data = 8'hAA;
    tick();
    wr_en = 1'b0;
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 8);
    chk("ovf_full", 32'(full), 1);

    // drain: each read gives a one-cycle rd_valid and data in order
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1;
      tick();
      chk("drain_valid", 32'(rd_valid), 1);
      chk("drain_data", 32'(rd_data), 32'(8'h10 + i));
      chk("drain_count", 32'(count), 32'(7 - i));
      chk("drain_ae", 32'(almost_empty), (7 - i <= 1) ? 1 : 0);
    end
    rd_en = 1'b0;
    tick();
    chk("drain_valid_pulse", 32'(rd_valid), 0);
    chk("drain_data_hold", 32'(rd_data), 32'h17);
    chk("drain_empty", 32'(empty), 1);
    chk("ovf_sticky", 32'(overflow), 1);

    // read on empty alone
    rd_en = 1'b1;
    tick();
    chk("udf_flag", 32'(underflow), 1);
    chk("udf_valid", 32'(rd_valid), 0);
    chk("udf_count", 32'(count), 0);

    // read on empty with simultaneous write: read rejected, write accepted
    wr_en = 1'b1;
    wr_data = 8'h77;
    tick();
    rd_en = 1'b0;
    chk("udf_wr_count", 32'(count), 1);
    chk("udf_wr_valid", 32'(rd_valid), 0);
    chk("udf_wr_empty", 32'(empty), 0);

    // flush with wr_en held high: write ignored
    clr = 1'b1;
    tick();
    clr = 1'b0;
    wr_en = 1'b0;
    chk("clr_udf", 32'(underflow), 0);
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_count", 32'(count), 0);
    chk("clr_empty", 32'(empty), 1);

    // prime to 4 then stream 20 cycles of simultaneous read/write; pointers wrap
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(8'h20 + i);
      tick();
    end
    chk("stream_prime", 32'(count), 4);
    for (int k = 0; k < 20; k++) begin
      wr_en = 1'b1;
      rd_en = 1'b1;
      wr_data = 8'(8'h24 + k);
      tick();
      chk("stream_count", 32'(count), 4);
      chk("stream_data", 32'(rd_data), 32'(8'h20 + k));
      chk("stream_valid", 32'(rd_valid), 1);
      chk("stream_flags", {30'd0, full, empty}, 0);
    end
    rd_en = 1'b0;
    wr_data = 8'h99;
    tick();
    wr_en = 1'b0;
    chk("pre_rst_count", 32'(count), 5);

    // async reset half-way through a clock period
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_empty", 32'(empty), 1);
    chk("arst_count", 32'(count), 0);
    chk("arst_rd_data", 32'(rd_data), 0);
    chk("arst_valid", 32'(rd_valid), 0);
    tick();
    rst = 1'b1;

    // FWFT: word visible the cycle after its write edge
    wr_en1 = 1'b1;
    wr_data1 = 8'h5C;
    tick();
    wr_en1 = 1'b0;
    chk("fwft_data", 32'(rd_data1), 32'h5C);
    chk("fwft_valid", 32'(rd_valid1), 1);
    rd_en1 = 1'b1;
    tick();
    rd_en1 = 1'b0;
    chk("fwft_pop_empty", 32'(empty1), 1);
    chk("fwft_pop_valid", 32'(rd_valid1), 0);

    wr_en1 = 1'b1;
    wr_data1 = 8'h5D;
    tick();
    wr_data1 = 8'h5E;
    tick();
    wr_en1 = 1'b0;
    chk("fwft_head", 32'(rd_data1), 32'h5D);
    rd_en1 = 1'b1;
    tick();
    rd_en1 = 1'b0;
    chk("fwft_next", 32'(rd_data1), 32'h5E);
    chk("fwft_count", 32'(count1), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
